// File: rtl/ysyx_23060203_sb_pkg.sv
`default_nettype none
// ysyx_23060203_sb_pkg: shared register-index type and perf event list for the IDU scoreboard.
// Revision: 1.0
package ysyx_23060203_sb_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [3:0] {
    PERF_IFU_FETCH,
    PERF_IFU_STALL,
    PERF_IDU_INST,
    PERF_LSU_LOAD,
    PERF_LSU_STORE,
    PERF_IDU_RAW,
    PERF_IDU_WAW,
    PERF_NUM
  } perf_event_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060203_sb_cnt.sv
`default_nettype none
// ysyx_23060203_sb_cnt: per-register pending-write counter, +1 on issue, -N on writeback, clamped.
// Revision: 1.0
module ysyx_23060203_sb_cnt #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic [DEC_W-1:0] i_dec,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int SW = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;
  logic [SW-1:0]    w_up;
  logic [SW-1:0]    w_dn;
  logic             w_under;
  logic [CNT_W-1:0] w_next;

  assign w_full  = &r_cnt;
  // An issue into a saturated counter is dropped so the count sticks at max.
  assign w_up    = SW'(r_cnt) + SW'(i_inc & ~w_full);
  assign w_dn    = SW'(i_dec);
  assign w_under = (w_dn > w_up);
  assign w_next  = w_under ? '0 : CNT_W'(w_up - w_dn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_next;
  end

  assign o_cnt = r_cnt;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      if (i_inc && w_full) $error("sb_cnt: issue while counter saturated");
      if (w_under)         $error("sb_cnt: writeback underflow");
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/ysyx_23060203_idu_scoreboard.sv
`default_nettype none
// ysyx_23060203_idu_scoreboard: multi-writer GPR scoreboard flagging RAW/WAW/full hazards for IDU.
// Revision: 1.0
module ysyx_23060203_idu_scoreboard
  import ysyx_23060203_sb_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int CNT_W     = 2,
  parameter int NWB       = 2,
  parameter int WAW_CHK   = 1,
  parameter int WB_BYPASS = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  reg_idx_t           rs1,
  input  logic               rs1_en,
  input  reg_idx_t           rs2,
  input  logic               rs2_en,
  input  reg_idx_t           rd,
  output logic               hazard,
  input  logic               iss_fire,
  input  logic [NWB-1:0]     wb_en,
  input  logic [NWB*REG_W-1:0] wb_rd,
  output logic               idle
);

  localparam int NSLOT = 1 << REG_W;
  localparam int DEC_W = $clog2(NWB + 1);

  logic [CNT_W-1:0] w_cnt [NSLOT];
  logic [NSLOT-1:0] w_wb_hit;
  logic [NSLOT-1:0] w_busy;

  // Every 5-bit index gets a slot so lookups never go out of range; untracked ones read as zero.
  generate
    for (genvar r = 0; r < NSLOT; r++) begin : g_reg
      if (r == 0 || r >= NREG) begin : g_none
        assign w_cnt[r]    = '0;
        assign w_wb_hit[r] = 1'b0;
        assign w_busy[r]   = 1'b0;
      end else begin : g_trk
        logic             w_inc;
        logic [DEC_W-1:0] w_dec;

        assign w_inc = iss_fire & (rd == reg_idx_t'(r));

        always_comb begin
          w_dec = '0;
          for (int k = 0; k < NWB; k++) begin
            if (wb_en[k] && (wb_rd[k*REG_W +: REG_W] == reg_idx_t'(r))) w_dec = w_dec + DEC_W'(1);
          end
        end

        ysyx_23060203_sb_cnt #(
          .CNT_W (CNT_W),
          .DEC_W (DEC_W)
        ) u_cnt (
          .clk   (clock),
          .rst_n (reset),
          .i_inc (w_inc),
          .i_dec (w_dec),
          .o_cnt (w_cnt[r])
        );

        assign w_wb_hit[r] = |w_dec;
        assign w_busy[r]   = |w_cnt[r];
      end
    end
  endgenerate

  logic [CNT_W-1:0] w_c1, w_c2, w_cd;
  logic             w_rs1_pend, w_rs2_pend, w_rs_haz, w_waw, w_full;

  assign w_c1 = w_cnt[rs1];
  assign w_c2 = w_cnt[rs2];
  assign w_cd = w_cnt[rd];

  // With bypass, the last outstanding write landing this cycle is visible through the regfile.
  assign w_rs1_pend = rs1_en && (rs1 != '0) && (w_c1 != '0) &&
                      !((WB_BYPASS != 0) && (w_c1 == CNT_W'(1)) && w_wb_hit[rs1]);
  assign w_rs2_pend = rs2_en && (rs2 != '0) && (w_c2 != '0) &&
                      !((WB_BYPASS != 0) && (w_c2 == CNT_W'(1)) && w_wb_hit[rs2]);
  assign w_rs_haz   = w_rs1_pend || w_rs2_pend;
  assign w_waw      = (WAW_CHK != 0) && (rd != '0) && (w_cd != '0);
  assign w_full     = (rd != '0) && (w_cd == {CNT_W{1'b1}});

  assign hazard = w_rs_haz || w_waw || w_full;
  assign idle   = ~|w_busy;

`ifndef SYNTHESIS
  longint unsigned r_perf_cnt [int'(PERF_NUM)];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(PERF_NUM); i++) r_perf_cnt[i] <= '0;
    end else if (hazard) begin
      if (w_rs_haz) r_perf_cnt[int'(PERF_IDU_RAW)] <= r_perf_cnt[int'(PERF_IDU_RAW)] + 1;
      else          r_perf_cnt[int'(PERF_IDU_WAW)] <= r_perf_cnt[int'(PERF_IDU_WAW)] + 1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_idu_scoreboard.sv
`default_nettype none
// tb_ysyx_23060203_idu_scoreboard: directed vectors against two scoreboard configurations.
// Revision: 1.0
module tb_ysyx_23060203_idu_scoreboard;
  import ysyx_23060203_sb_pkg::*;

  logic          clock;
  logic          reset;
  reg_idx_t      rs1, rs2, rd;
  logic          rs1_en, rs2_en, iss_fire;
  logic [1:0]    wb_en;
  logic [9:0]    wb_rd;
  logic          haz_a, idle_a, haz_b, idle_b;

  // A: default build (WAW check on, no bypass). B: WAW check off, writeback bypass on.
  ysyx_23060203_idu_scoreboard #(
    .NREG(32), .CNT_W(2), .NWB(2), .WAW_CHK(1), .WB_BYPASS(0)
  ) u_dut_a (
    .clock(clock), .reset(reset), .rs1(rs1), .rs1_en(rs1_en), .rs2(rs2), .rs2_en(rs2_en),
    .rd(rd), .hazard(haz_a), .iss_fire(iss_fire), .wb_en(wb_en), .wb_rd(wb_rd), .idle(idle_a)
  );

  ysyx_23060203_idu_scoreboard #(
    .NREG(32), .CNT_W(2), .NWB(2), .WAW_CHK(0), .WB_BYPASS(1)
  ) u_dut_b (
    .clock(clock), .reset(reset), .rs1(rs1), .rs1_en(rs1_en), .rs2(rs2), .rs2_en(rs2_en),
    .rd(rd), .hazard(haz_b), .iss_fire(iss_fire), .wb_en(wb_en), .wb_rd(wb_rd), .idle(idle_b)
  );

  typedef struct {
    string nm;
    logic  ha, ia, hb, ib;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".hazA"}, haz_a,  e.ha);
      chk({e.nm, ".idleA"}, idle_a, e.ia);
      chk({e.nm, ".hazB"}, haz_b,  e.hb);
      chk({e.nm, ".idleB"}, idle_b, e.ib);
    end
  end

  task automatic vec(input string nm,
                     input reg_idx_t r1, input bit e1, input reg_idx_t r2, input bit e2,
                     input reg_idx_t d, input bit iss, input bit [1:0] we,
                     input reg_idx_t w0, input reg_idx_t w1,
                     input bit ha, input bit ia, input bit hb, input bit ib);
    exp_t e;
    rs1 = r1; rs1_en = e1; rs2 = r2; rs2_en = e2; rd = d; iss_fire = iss;
    wb_en = we; wb_rd = {w1, w0};
    e.nm = nm; e.ha = ha; e.ia = ia; e.hb = hb; e.ib = ib;
    q.push_back(e);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    rs1 = '0; rs1_en = 1'b0; rs2 = '0; rs2_en = 1'b0; rd = '0; iss_fire = 1'b0;
    wb_en = '0; wb_rd = '0;
    repeat (2) @(posedge clock);
    #1;
    //        name        rs1 e1 rs2 e2 rd iss we     w0 w1  hA iA hB iB
    vec("rst",        5, 1, 0, 0, 0, 0, 2'b00, 0, 0,  0, 1, 0, 1);
    reset = 1'b1;
    vec("iss5",       0, 0, 0, 0, 5, 1, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("raw5",       5, 1, 0, 0, 0, 0, 2'b00, 0, 0,  1, 0, 1, 0);
    vec("wb5",        5, 1, 0, 0, 0, 0, 2'b01, 5, 0,  1, 0, 0, 0);
    vec("clr5",       5, 1, 0, 0, 0, 0, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("iss0",       0, 1, 0, 0, 0, 1, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("rs0",        0, 1, 0, 0, 0, 0, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("iss6",       0, 0, 0, 0, 6, 1, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("rs2off",     0, 1, 6, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0);
    vec("rs2on",      0, 0, 6, 1, 0, 0, 2'b00, 0, 0,  1, 0, 1, 0);
    vec("wb6",        0, 0, 6, 0, 0, 0, 2'b10, 0, 6,  0, 0, 0, 0);
    vec("iss7a",      0, 0, 0, 0, 7, 1, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("iss7wb",     0, 0, 0, 0, 7, 1, 2'b10, 0, 7,  1, 0, 0, 0);
    vec("raw7",       7, 1, 0, 0, 0, 0, 2'b00, 0, 0,  1, 0, 1, 0);
    vec("iss7b",      0, 0, 0, 0, 7, 1, 2'b00, 0, 0,  1, 0, 0, 0);
    vec("wb77",       7, 1, 0, 0, 0, 0, 2'b11, 7, 7,  1, 0, 1, 0);
    vec("clr7",       7, 1, 0, 0, 0, 0, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("iss9a",      0, 0, 0, 0, 9, 1, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("iss9b",      0, 0, 0, 0, 9, 1, 2'b00, 0, 0,  1, 0, 0, 0);
    vec("iss9c",      0, 0, 0, 0, 9, 1, 2'b00, 0, 0,  1, 0, 0, 0);
    vec("full9",      0, 0, 0, 0, 9, 0, 2'b00, 0, 0,  1, 0, 1, 0);
    vec("wbfull9",    0, 0, 0, 0, 9, 0, 2'b01, 9, 0,  1, 0, 1, 0);
    vec("waw9",       0, 0, 0, 0, 9, 0, 2'b00, 0, 0,  1, 0, 0, 0);
    vec("wb99",       0, 0, 0, 0, 0, 0, 2'b11, 9, 9,  0, 0, 0, 0);
    vec("idle9",      0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("ld3",        0, 0, 0, 0, 3, 1, 2'b01, 0, 0,  0, 1, 0, 1);
    vec("alu3",       1, 1, 2, 1, 3, 0, 2'b00, 0, 0,  1, 0, 0, 0);
    vec("lsuwb3",     0, 0, 0, 0, 3, 0, 2'b10, 0, 3,  1, 0, 0, 0);
    vec("free3",      0, 0, 0, 0, 3, 0, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("iss5x",      0, 0, 0, 0, 5, 1, 2'b00, 0, 0,  0, 1, 0, 1);
    vec("iss5y",      0, 0, 0, 0, 5, 1, 2'b00, 0, 0,  1, 0, 0, 0);
    reset = 1'b0;
    vec("rstmid",     5, 1, 0, 0, 0, 0, 2'b00, 0, 0,  0, 1, 0, 1);
    reset = 1'b1;
    vec("postrst",    5, 1, 0, 0, 0, 0, 2'b00, 0, 0,  0, 1, 0, 1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain actual=%0d required=0 pending entries", q.size());
    end
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
